// File: rtl/coffee_pkg.sv
// Shared state encoding, default widths/prices and the price lookup for the brew controller.
package coffee_pkg;

    localparam int unsigned CREDIT_W_DEF = 4;
    localparam int unsigned PRICE_0_DEF  = 3;
    localparam int unsigned PRICE_1_DEF  = 5;
    localparam int unsigned PRICE_2_DEF  = 7;
    localparam int unsigned PRICE_3_DEF  = 9;

    typedef enum logic [2:0] {
        StIdle,
        StHeat,
        StBrew,
        StDisp,
        StChange
    } brew_state_e;

    function automatic int unsigned price_of(
        input logic [1:0]  sel,
        input int unsigned p0 = PRICE_0_DEF,
        input int unsigned p1 = PRICE_1_DEF,
        input int unsigned p2 = PRICE_2_DEF,
        input int unsigned p3 = PRICE_3_DEF
    );
        int unsigned price;
        unique case (sel)
            2'd0: price = p0;
            2'd1: price = p1;
            2'd2: price = p2;
            2'd3: price = p3;
        endcase
        return price;
    endfunction

endpackage

// File: rtl/coffee_brew_ctrl_if.sv
// Coin/button inputs and actuator/status outputs of the brew controller.
interface coffee_brew_ctrl_if #(
    parameter int unsigned CREDIT_W = coffee_pkg::CREDIT_W_DEF
);
    logic                coin_one;
    logic                coin_five;
    logic [1:0]          sel;
    logic                start;
    logic                cancel;
    logic [CREDIT_W-1:0] credit;
    logic                heater_on;
    logic                pump_on;
    logic                cup_release;
    logic                change_one;
    logic                coin_reject;
    logic                busy;

    modport master (
        output coin_one, coin_five, sel, start, cancel,
        input  credit, heater_on, pump_on, cup_release, change_one, coin_reject, busy
    );

    modport slave (
        input  coin_one, coin_five, sel, start, cancel,
        output credit, heater_on, pump_on, cup_release, change_one, coin_reject, busy
    );
endinterface

// File: rtl/brew_timer.sv
// Loadable down-counter used for phase durations and the change-return gap.
module brew_timer #(
    parameter int unsigned TMR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] value,
    output logic [TMR_W-1:0] count,
    output logic             done
);

    logic [TMR_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= value;
        end else if (count_q != '0) begin
            count_q <= count_q - TMR_W'(1);
        end
    end

    assign count = count_q;
    assign done  = (count_q == '0);

endmodule

// File: rtl/coffee_brew_ctrl.sv
// Coffee maker sequencer: coin credit, price check, heat/brew/dispense phases, change return.
module coffee_brew_ctrl
    import coffee_pkg::*;
#(
    parameter int unsigned CREDIT_W   = CREDIT_W_DEF,
    parameter int unsigned PRICE_0    = PRICE_0_DEF,
    parameter int unsigned PRICE_1    = PRICE_1_DEF,
    parameter int unsigned PRICE_2    = PRICE_2_DEF,
    parameter int unsigned PRICE_3    = PRICE_3_DEF,
    parameter int unsigned TMR_W      = 8,
    parameter int unsigned HEAT_CYC   = 16,
    parameter int unsigned BREW_CYC   = 32,
    parameter int unsigned DISP_CYC   = 8,
    parameter int unsigned CHANGE_GAP = 2
) (
    input logic               clk,
    input logic               reset,
    coffee_brew_ctrl_if.slave bus
);

    localparam int unsigned      SUM_W      = CREDIT_W + 1;
    localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'((1 << CREDIT_W) - 1);
    // Timer runs value..0, so a phase of N cycles loads N-1.
    localparam logic [TMR_W-1:0] HEAT_LOAD  = TMR_W'(HEAT_CYC - 1);
    localparam logic [TMR_W-1:0] BREW_LOAD  = TMR_W'(BREW_CYC - 1);
    localparam logic [TMR_W-1:0] DISP_LOAD  = TMR_W'(DISP_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(CHANGE_GAP);

    brew_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d, credit_kept;
    logic [SUM_W-1:0]    coin_add, coin_sum;
    logic                coin_any, coin_ovf, paid;
    int unsigned         price;
    logic                tmr_load, tmr_done;
    logic [TMR_W-1:0]    tmr_value, tmr_count;
    logic                reject_d, change_d;
    logic                heater_q, pump_q, cup_q, change_q, reject_q, busy_q;

    brew_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_value),
        .count (tmr_count),
        .done  (tmr_done)
    );

    assign coin_any    = bus.coin_one | bus.coin_five;
    assign coin_add    = (bus.coin_one ? SUM_W'(1) : '0) + (bus.coin_five ? SUM_W'(5) : '0);
    assign coin_sum    = {1'b0, credit_q} + coin_add;
    assign coin_ovf    = (coin_sum > CREDIT_MAX);
    assign credit_kept = coin_ovf ? credit_q : coin_sum[CREDIT_W-1:0];
    assign price       = price_of(bus.sel, PRICE_0, PRICE_1, PRICE_2, PRICE_3);
    // Price check uses the pre-coin credit; coins arriving with start still count afterwards.
    assign paid        = (32'(credit_q) >= price);

    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
        reject_d  = coin_any;
        unique case (state_q)
            StIdle: begin
                reject_d = coin_any && coin_ovf;
                credit_d = credit_kept;
                if (bus.cancel) begin
                    if (credit_q != '0) begin
                        state_d  = StChange;
                        tmr_load = 1'b1;
                    end
                end else if (bus.start && paid) begin
                    state_d   = StHeat;
                    credit_d  = credit_kept - CREDIT_W'(price);
                    tmr_load  = 1'b1;
                    tmr_value = HEAT_LOAD;
                end
            end
            StHeat: begin
                if (tmr_done) begin
                    state_d   = StBrew;
                    tmr_load  = 1'b1;
                    tmr_value = BREW_LOAD;
                end
            end
            StBrew: begin
                if (tmr_done) begin
                    state_d   = StDisp;
                    tmr_load  = 1'b1;
                    tmr_value = DISP_LOAD;
                end
            end
            StDisp: begin
                if (tmr_done) begin
                    state_d  = (credit_q != '0) ? StChange : StIdle;
                    tmr_load = (credit_q != '0);
                end
            end
            StChange: begin
                if (tmr_done) begin
                    if (credit_q != '0) begin
                        credit_d = credit_q - CREDIT_W'(1);
                    end
                    if (credit_q <= CREDIT_W'(1)) begin
                        state_d = StIdle;
                    end else begin
                        tmr_load  = 1'b1;
                        tmr_value = GAP_LOAD;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A pulse cycle is a CHANGE cycle whose timer reads zero; predict it one edge ahead.
    assign change_d = (state_d == StChange) &&
                      (tmr_load ? (tmr_value == '0) : (tmr_count == TMR_W'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            credit_q <= '0;
            heater_q <= 1'b0;
            pump_q   <= 1'b0;
            cup_q    <= 1'b0;
            change_q <= 1'b0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            heater_q <= (state_d == StHeat) || (state_d == StBrew);
            pump_q   <= (state_d == StBrew);
            cup_q    <= (state_d == StDisp);
            change_q <= change_d;
            reject_q <= reject_d;
            busy_q   <= (state_d != StIdle);
        end
    end

    assign bus.credit      = credit_q;
    assign bus.heater_on   = heater_q;
    assign bus.pump_on     = pump_q;
    assign bus.cup_release = cup_q;
    assign bus.change_one  = change_q;
    assign bus.coin_reject = reject_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_coffee_brew_ctrl.sv
// Bench for coffee_brew_ctrl: timeline model of expected outputs plus directed scenarios.
module tb_coffee_brew_ctrl;

    localparam int H    = 16;
    localparam int B    = 32;
    localparam int D    = 8;
    localparam int G    = 2;
    localparam int MAXC = 15;
    localparam int NS   = 4096;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    coffee_brew_ctrl_if bus ();

    coffee_brew_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int price_tbl[4] = '{3, 5, 7, 9};

    // Expected outputs per cycle slot (slot n = the cycle after the n-th rising edge).
    int e_credit[NS];
    bit e_heat[NS], e_pump[NS], e_cup[NS], e_chg[NS], e_rej[NS], e_busy[NS];
    int cyc = 0;
    int busy_end = -1;
    bit model_ok = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (slot %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_slot(input int t, input int c, input bit h, input bit p, input bit u,
                            input bit g, input bit b);
        if (t >= 0 && t < NS) begin
            e_credit[t] = c;
            e_heat[t]   = h;
            e_pump[t]   = p;
            e_cup[t]    = u;
            e_chg[t]    = g;
            e_busy[t]   = b;
            e_rej[t]    = 1'b0;
        end
    endtask

    // r units refunded: a pulse every G+1 slots starting at s, credit drops after each pulse.
    task automatic sched_change(input int s, input int r);
        int last;
        last = s + (r - 1) * (G + 1);
        for (int t = s; t <= last; t++)
            set_slot(t, r - (t - s + G) / (G + 1), 0, 0, 0, ((t - s) % (G + 1)) == 0, 1);
        busy_end = last;
        set_slot(last + 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sched_brew(input int s, input int r);
        int cs;
        for (int i = 0; i < H; i++) set_slot(s + i, r, 1, 0, 0, 0, 1);
        for (int i = 0; i < B; i++) set_slot(s + H + i, r, 1, 1, 0, 0, 1);
        for (int i = 0; i < D; i++) set_slot(s + H + B + i, r, 0, 0, 1, 0, 1);
        cs = s + H + B + D;
        if (r > 0) begin
            sched_change(cs, r);
        end else begin
            busy_end = cs - 1;
            set_slot(cs, 0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin : model
        int s, c, add, tot;
        bit ovf, coin;
        forever begin
            @(posedge clk);
            s = cyc + 1;
            if (s < NS) begin
                coin = bus.coin_one | bus.coin_five;
                if (reset) begin
                    set_slot(s, 0, 0, 0, 0, 0, 0);
                    busy_end = -1;
                    model_ok = 1'b1;
                end else if (model_ok) begin
                    if (s - 1 <= busy_end) begin
                        e_rej[s] = coin;
                    end else begin
                        c   = e_credit[s-1];
                        add = (bus.coin_one ? 1 : 0) + (bus.coin_five ? 5 : 0);
                        ovf = (c + add) > MAXC;
                        tot = ovf ? c : c + add;
                        set_slot(s, tot, 0, 0, 0, 0, 0);
                        if (bus.cancel) begin
                            if (c > 0) sched_change(s, tot);
                        end else if (bus.start && c >= price_tbl[bus.sel]) begin
                            sched_brew(s, tot - price_tbl[bus.sel]);
                        end
                        e_rej[s] = coin && ovf;
                    end
                end
            end
            cyc = s;
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (model_ok && cyc < NS) begin
                check("credit", int'(bus.credit), e_credit[cyc]);
                check("heater_on", int'(bus.heater_on), int'(e_heat[cyc]));
                check("pump_on", int'(bus.pump_on), int'(e_pump[cyc]));
                check("cup_release", int'(bus.cup_release), int'(e_cup[cyc]));
                check("change_one", int'(bus.change_one), int'(e_chg[cyc]));
                check("coin_reject", int'(bus.coin_reject), int'(e_rej[cyc]));
                check("busy", int'(bus.busy), int'(e_busy[cyc]));
            end
        end
    end

    // Cumulative output statistics sampled just after each rising edge.
    int m_heat = 0, m_brew = 0, m_cup = 0, m_chg = 0, m_badgap = 0;
    initial begin : monitor
        int m_cyc, last_chg;
        m_cyc    = 0;
        last_chg = -100;
        forever begin
            @(posedge clk);
            #1;
            m_cyc++;
            if (bus.heater_on && !bus.pump_on) m_heat++;
            if (bus.heater_on && bus.pump_on) m_brew++;
            if (bus.cup_release) m_cup++;
            if (bus.change_one) begin
                m_chg++;
                if ((m_cyc - last_chg) < 10 && (m_cyc - last_chg) != G + 1) m_badgap++;
                last_chg = m_cyc;
            end
        end
    end

    task automatic pulse(input bit c1, input bit c5, input bit st, input bit cn,
                         input logic [1:0] s);
        bus.coin_one  = c1;
        bus.coin_five = c5;
        bus.start     = st;
        bus.cancel    = cn;
        bus.sel       = s;
        @(negedge clk);
        bus.coin_one  = 1'b0;
        bus.coin_five = 1'b0;
        bus.start     = 1'b0;
        bus.cancel    = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (bus.busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) check("wait_idle_timeout", int'(bus.busy), 0);
    endtask

    task automatic wait_pump(input int limit);
        int n;
        n = 0;
        while (!bus.pump_on && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!bus.pump_on) check("wait_pump_timeout", int'(bus.pump_on), 1);
    endtask

    int h0, b0, u0, g0, gap0;

    task automatic snap();
        h0   = m_heat;
        b0   = m_brew;
        u0   = m_cup;
        g0   = m_chg;
        gap0 = m_badgap;
    endtask

    initial begin : stim
        bus.coin_one  = 1'b0;
        bus.coin_five = 1'b0;
        bus.start     = 1'b0;
        bus.cancel    = 1'b0;
        bus.sel       = 2'd0;
        tick(3);
        check("reset_credit", int'(bus.credit), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_heater", int'(bus.heater_on), 0);
        reset = 1'b0;
        tick(1);

        // 1: exact payment, full brew, no change
        pulse(0, 1, 0, 0, 0);
        pulse(1, 0, 0, 0, 0);
        pulse(1, 0, 0, 0, 0);
        check("t1_credit", int'(bus.credit), 7);
        check("t1_model_credit", e_credit[cyc], 7);
        snap();
        pulse(0, 0, 1, 0, 2);
        check("t1_credit_paid", int'(bus.credit), 0);
        check("t1_heater_first", int'(bus.heater_on), 1);
        wait_idle(200);
        check("t1_heat_cycles", m_heat - h0, 16);
        check("t1_brew_cycles", m_brew - b0, 32);
        check("t1_cup_cycles", m_cup - u0, 8);
        check("t1_change_pulses", m_chg - g0, 0);
        check("t1_busy_end", int'(bus.busy), 0);
        tick(2);

        // 2: overpayment, change returned after dispense
        pulse(0, 1, 0, 0, 0);
        pulse(0, 1, 0, 0, 0);
        check("t2_credit", int'(bus.credit), 10);
        snap();
        pulse(0, 0, 1, 0, 0);
        check("t2_credit_paid", int'(bus.credit), 7);
        check("t2_model_credit_paid", e_credit[cyc], 7);
        wait_idle(300);
        check("t2_change_pulses", m_chg - g0, 7);
        check("t2_bad_gaps", m_badgap - gap0, 0);
        check("t2_credit_end", int'(bus.credit), 0);
        tick(2);

        // 3: paired coins and overflow rejection
        pulse(1, 1, 0, 0, 0);
        check("t3_credit6", int'(bus.credit), 6);
        pulse(1, 1, 0, 0, 0);
        check("t3_credit12", int'(bus.credit), 12);
        pulse(0, 1, 0, 0, 0);
        check("t3_reject", int'(bus.coin_reject), 1);
        check("t3_credit_kept", int'(bus.credit), 12);
        tick(1);
        check("t3_reject_once", int'(bus.coin_reject), 0);
        snap();
        pulse(0, 0, 0, 1, 0);
        wait_idle(100);
        check("t3_refund_pulses", m_chg - g0, 12);
        tick(2);

        // 4: underpaid start ignored, cancel refunds
        repeat (4) pulse(1, 0, 0, 0, 0);
        pulse(0, 0, 1, 0, 1);
        check("t4_busy", int'(bus.busy), 0);
        check("t4_credit", int'(bus.credit), 4);
        snap();
        pulse(0, 0, 0, 1, 0);
        wait_idle(100);
        check("t4_refund_pulses", m_chg - g0, 4);
        check("t4_credit_end", int'(bus.credit), 0);
        tick(2);

        // 5: busy lockout
        pulse(0, 1, 0, 0, 0);
        pulse(1, 0, 0, 0, 0);
        pulse(1, 0, 0, 0, 0);
        snap();
        pulse(0, 0, 1, 0, 2);
        tick(4);
        pulse(0, 0, 0, 1, 0);
        wait_pump(100);
        pulse(1, 0, 0, 0, 0);
        check("t5_reject", int'(bus.coin_reject), 1);
        check("t5_credit", int'(bus.credit), 0);
        wait_idle(200);
        check("t5_heat_cycles", m_heat - h0, 16);
        check("t5_brew_cycles", m_brew - b0, 32);
        check("t5_cup_cycles", m_cup - u0, 8);
        tick(2);

        // 6: reset mid-brew, then cancel outranking start
        pulse(0, 1, 0, 0, 0);
        pulse(1, 0, 0, 0, 0);
        pulse(1, 0, 0, 0, 0);
        pulse(0, 0, 1, 0, 2);
        wait_pump(100);
        tick(3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_rst_heater", int'(bus.heater_on), 0);
        check("t6_rst_pump", int'(bus.pump_on), 0);
        check("t6_rst_busy", int'(bus.busy), 0);
        check("t6_rst_credit", int'(bus.credit), 0);
        pulse(0, 1, 0, 0, 0);
        repeat (4) pulse(1, 0, 0, 0, 0);
        check("t6_credit9", int'(bus.credit), 9);
        snap();
        pulse(0, 0, 1, 1, 0);
        check("t6_busy", int'(bus.busy), 1);
        check("t6_no_heat", int'(bus.heater_on), 0);
        wait_idle(100);
        check("t6_refund_pulses", m_chg - g0, 9);
        check("t6_heat_total", m_heat - h0, 0);
        check("t6_credit_end", int'(bus.credit), 0);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
